// File: rtl/sm_rom_arbiter.sv
// Two-port (fetch/data) arbiter in front of a shared combinational ROM, fixed read latency of one cycle.
// Define SM_ROM_ARB_RR_EN for round-robin on simultaneous requests; default build gives fetch priority.
module sm_rom_arbiter #(
   parameter int unsigned SIZE = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic        f_gnt,
   output logic        f_rvalid,
   output logic [31:0] f_rdata,
   output logic        f_err,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic [31:0] rom_a,
   input  logic [31:0] rom_rd
);

   typedef enum logic {LW_FETCH = 1'b0, LW_DATA = 1'b1} winner_t;

   winner_t     last_win;
   logic [3:0]  f_stall;
   logic [3:0]  d_stall;
   logic        f_starve;
   logic        d_starve;
   logic        f_pick;
   logic        oor;
   logic [31:0] rd_word;

   assign f_starve = (f_stall == 4'hf);
   assign d_starve = (d_stall == 4'hf);

   // Winner when both ports request: starvation override first, fetch wins a double starve.
   always_comb begin
      f_pick = 1'b1;
      if (f_starve) begin
         f_pick = 1'b1;
      end else if (d_starve) begin
         f_pick = 1'b0;
      end else begin
`ifdef SM_ROM_ARB_RR_EN
         f_pick = (last_win == LW_DATA);
`else
         f_pick = 1'b1;
`endif
      end
   end

`ifndef SM_ROM_ARB_RR_EN
   // Last-winner is tracked in both builds but only steers arbitration with round-robin.
   logic unused_last_win;
   assign unused_last_win = last_win;
`endif

   always_comb begin
      f_gnt = 1'b0;
      d_gnt = 1'b0;
      if (rst_n) begin
         if (f_req && d_req) begin
            f_gnt = f_pick;
            d_gnt = !f_pick;
         end else begin
            f_gnt = f_req;
            d_gnt = d_req;
         end
      end
   end

   assign rom_a   = d_gnt ? d_addr : f_addr;
   assign oor     = ((rom_a >> 2) >= SIZE);
   assign rd_word = oor ? '0 : rom_rd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_win <= LW_DATA;
         f_stall  <= '0;
         d_stall  <= '0;
         f_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         f_rdata  <= '0;
         d_rdata  <= '0;
         f_err    <= 1'b0;
         d_err    <= 1'b0;
      end else begin
         f_rvalid <= f_gnt;
         d_rvalid <= d_gnt;
         if (f_gnt) begin
            f_rdata  <= rd_word;
            f_err    <= oor;
            last_win <= LW_FETCH;
         end
         if (d_gnt) begin
            d_rdata  <= rd_word;
            d_err    <= oor;
            last_win <= LW_DATA;
         end
         if (f_gnt) begin
            f_stall <= '0;
         end else if (f_req && !f_starve) begin
            f_stall <= f_stall + 4'd1;
         end
         if (d_gnt) begin
            d_stall <= '0;
         end else if (d_req && !d_starve) begin
            d_stall <= d_stall + 4'd1;
         end
      end
   end

endmodule
